mips_fetch_queue: RTL and testbench

//   Instruction-fetch front end for the pipelined MIPS32 core; sits directly upstream of IF/ID.

---
 rtl/mips_fetch_queue.sv | 109 ++++++++++
 tb/tb_mips_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: fetches words over a req/ack port into a show-ahead FIFO
// feeding decode. Taken-branch redirects flush and restart fetch; halt stops fetch for good.
module mips_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 10
) (
    input  logic                       clk1,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [AW-1:0]              redirect_pc,
    input  logic                       halt,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [31:0]                id_ir,
    output logic [31:0]                id_npc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StBoot, StFetch, StHalted} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   ir_mem  [DEPTH];
    logic [AW-1:0] npc_mem [DEPTH];
    logic          push;
    logic          pop;
    logic [AW-1:0] pc_inc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:   state_d = StFetch;
            StFetch:  if (halt) state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StBoot;
        endcase
    end

    // Request depends only on registers, so memory sees a stable request for the whole cycle.
    assign imem_req  = (state_q == StFetch) && (count_q < CW'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign pc_inc    = fetch_pc_q + AW'(1);

    // Redirect wins over everything: same-cycle ack and pop are both dropped.
    assign push = imem_req && imem_ack && !redirect_valid;
    assign pop  = id_valid && id_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = pc_inc;
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk1) begin
        if (push) begin
            ir_mem[wr_ptr_q]  <= imem_rdata;
            npc_mem[wr_ptr_q] <= pc_inc;
        end
    end

    assign id_valid = (count_q != '0);
    assign id_ir    = id_valid ? ir_mem[rd_ptr_q] : 32'h0;
    assign id_npc   = id_valid ? 32'(npc_mem[rd_ptr_q]) : 32'h0;
    assign count    = count_q;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Self-checking bench for mips_fetch_queue: queue-based reference model checked every cycle,
// directed literal scenarios, randomized stalls/redirects, and an AW=4 instance for PC wrap.
module tb_mips_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic [2:0]    count;

    // Narrow-address instance for the PC wrap case.
    logic          s_req;
    logic [3:0]    s_addr;
    logic          s_ack;
    logic [31:0]   s_rdata;
    logic          s_redirect;
    logic [3:0]    s_rpc;
    logic          s_valid;
    logic [31:0]   s_ir;
    logic [31:0]   s_npc;
    logic [2:0]    s_count;

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    // Memory image: mem[k] = 0x100 + k
    assign imem_rdata = 32'h100 + 32'(imem_addr);
    assign s_rdata    = 32'h100 + 32'(s_addr);

    mips_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc),
        .count          (count)
    );

    mips_fetch_queue #(.DEPTH(DEPTH), .AW(4)) dut_w (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req       (s_req),
        .imem_addr      (s_addr),
        .imem_ack       (s_ack),
        .imem_rdata     (s_rdata),
        .redirect_valid (s_redirect),
        .redirect_pc    (s_rpc),
        .halt           (1'b0),
        .id_valid       (s_valid),
        .id_ready       (1'b0),
        .id_ir          (s_ir),
        .id_npc         (s_npc),
        .count          (s_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of fetched words plus the fetch PC and run state.
    logic [31:0]   q_ir  [$];
    logic [31:0]   q_npc [$];
    logic [AW-1:0] m_pc;
    bit            m_started;
    bit            m_halted;

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            q_ir.delete();
            q_npc.delete();
            m_pc      = '0;
            m_started = 0;
            m_halted  = 0;
        end else begin
            bit req;
            req = m_started && !m_halted && (q_ir.size() < DEPTH);
            if (redirect_valid) begin
                q_ir.delete();
                q_npc.delete();
                m_pc = redirect_pc;
            end else begin
                if (q_ir.size() > 0 && id_ready) begin
                    void'(q_ir.pop_front());
                    void'(q_npc.pop_front());
                end
                if (req && imem_ack) begin
                    q_ir.push_back(32'h100 + 32'(m_pc));
                    q_npc.push_back(32'((m_pc + 1) % (1 << AW)));
                    m_pc = AW'((m_pc + 1) % (1 << AW));
                end
            end
            if (m_started && halt) m_halted = 1;
            m_started = 1;
        end
    end

    always @(negedge clk1) begin
        if (rst_n) begin
            int n;
            n = q_ir.size();
            chk("valid", 32'(id_valid), 32'(n != 0));
            chk("count", 32'(count), 32'(n));
            chk("ir", id_ir, (n != 0) ? q_ir[0] : 32'h0);
            chk("npc", id_npc, (n != 0) ? q_npc[0] : 32'h0);
            chk("req", 32'(imem_req), 32'(m_started && !m_halted && n < DEPTH));
            chk("addr", 32'(imem_addr), 32'(m_pc));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic idle_inputs();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        id_ready       = 1'b0;
        s_ack          = 1'b0;
        s_redirect     = 1'b0;
        s_rpc          = '0;
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        idle_inputs();
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_ir", id_ir, 32'h0);
        chk("rst_npc", id_npc, 32'h0);
        chk("rst_count", 32'(count), 32'h0);

        // Streaming: first instruction visible after the 2nd edge
        @(negedge clk1);
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        id_ready = 1'b1;
        cyc(1);
        chk("boot_valid", 32'(id_valid), 32'h0);
        cyc(1);
        chk("first_valid", 32'(id_valid), 32'h1);
        chk("first_ir", id_ir, 32'h100);
        chk("first_npc", id_npc, 32'h1);
        cyc(1);
        chk("second_ir", id_ir, 32'h101);
        chk("second_npc", id_npc, 32'h2);

        // Backpressure: fill to DEPTH, then drain in order
        do_reset();
        imem_ack = 1'b1;
        cyc(6);
        chk("full_count", 32'(count), 32'h4);
        chk("full_req", 32'(imem_req), 32'h0);
        chk("full_addr", 32'(imem_addr), 32'h4);
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_ir", id_ir, 32'h100 + 32'(i));
            cyc(1);
        end

        // Redirect with count=3 and a same-cycle ack
        do_reset();
        imem_ack = 1'b1;
        cyc(4);
        chk("pre_redir_count", 32'(count), 32'h3);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h20;
        cyc(1);
        redirect_valid = 1'b0;
        chk("redir_count", 32'(count), 32'h0);
        chk("redir_valid", 32'(id_valid), 32'h0);
        chk("redir_addr", 32'(imem_addr), 32'h20);
        id_ready = 1'b1;
        cyc(1);
        chk("redir_ir", id_ir, 32'h120);
        chk("redir_npc", id_npc, 32'h21);

        // Halt with two entries buffered
        do_reset();
        imem_ack = 1'b1;
        cyc(3);
        imem_ack = 1'b0;
        halt     = 1'b1;
        cyc(1);
        halt     = 1'b0;
        imem_ack = 1'b1;
        chk("halt_req", 32'(imem_req), 32'h0);
        chk("halt_count", 32'(count), 32'h2);
        id_ready = 1'b1;
        cyc(2);
        chk("halt_drained", 32'(count), 32'h0);
        cyc(3);
        chk("halt_empty", 32'(id_valid), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h30;
        cyc(1);
        redirect_valid = 1'b0;
        chk("halt_redir_addr", 32'(imem_addr), 32'h30);
        chk("halt_redir_req", 32'(imem_req), 32'h0);
        cyc(2);
        chk("halt_redir_valid", 32'(id_valid), 32'h0);

        // PC wrap on the AW=4 instance
        do_reset();
        cyc(2);
        s_redirect = 1'b1;
        s_rpc      = 4'hF;
        cyc(1);
        s_redirect = 1'b0;
        chk("wrap_addr_f", 32'(s_addr), 32'hF);
        chk("wrap_req", 32'(s_req), 32'h1);
        s_ack = 1'b1;
        cyc(1);
        s_ack = 1'b0;
        chk("wrap_ir", s_ir, 32'h10F);
        chk("wrap_npc", s_npc, 32'h0);
        chk("wrap_addr_0", 32'(s_addr), 32'h0);

        // Asynchronous reset mid-cycle with two entries buffered
        do_reset();
        imem_ack = 1'b1;
        cyc(3);
        chk("pre_arst_count", 32'(count), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(id_valid), 32'h0);
        chk("arst_req", 32'(imem_req), 32'h0);
        chk("arst_count", 32'(count), 32'h0);

        // Random ack/ready stalls with occasional redirects
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            imem_ack       = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 63) == 0);
            redirect_pc    = AW'($urandom_range(0, 1023));
            cyc(1);
        end
        idle_inputs();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
